// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes and debounces a raw push-button line and
// derives press/release/short/long/auto-repeat event pulses.
// Ports:
//   clk           - system clock, all logic on the rising edge
//   reset         - synchronous active-high reset
//   d_in          - raw asynchronous button line (1 = pressed)
//   btn_level     - debounced button level
//   press_pulse   - one-cycle pulse on accepted press
//   release_pulse - one-cycle pulse on accepted release
//   short_pulse   - with release_pulse when no long_pulse fired that press
//   long_pulse    - LONG_CYCLES cycles after press_pulse while held
//   repeat_pulse  - every REPEAT_CYCLES cycles after long_pulse while held
module button_debouncer #(
  parameter int STABLE_CYCLES = 20,
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam int PW = $clog2(REPEAT_CYCLES) + 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [PW-1:0] REP_LAST  = PW'(REPEAT_CYCLES - 1);

  localparam logic [1:0] S_RELEASED     = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  logic          r_d_meta;
  logic          r_d_sync;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [PW-1:0] r_rep_cnt;
  logic          r_long_fired;
  logic          r_press;
  logic          r_release;
  logic          r_short;
  logic          r_long;
  logic          r_repeat;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_press_acc;
  logic          w_rel_acc;
  logic          w_held;
  logic          w_long_hit;
  logic          w_rep_hit;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_acc = 1'b0;
    w_rel_acc   = 1'b0;
    case (r_state)
      S_RELEASED: begin
        if (r_d_sync) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_PRESS_WAIT: begin
        if (!r_d_sync) begin
          w_state_nxt = S_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
          w_press_acc = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PRESSED: begin
        if (!r_d_sync) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      default: begin
        if (r_d_sync) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_RELEASED;
          w_cnt_nxt   = '0;
          w_rel_acc   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  // A release accepted this edge wins over any hold-timer event.
  assign w_held     = (r_state == S_PRESSED) ||
                      (r_state == S_RELEASE_WAIT);
  assign w_long_hit = w_held && !r_long_fired &&
                      (r_hold_cnt == HOLD_LAST) && !w_rel_acc;
  assign w_rep_hit  = w_held && r_long_fired &&
                      (r_rep_cnt == REP_LAST) && !w_rel_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_meta     <= 1'b0;
      r_d_sync     <= 1'b0;
      r_state      <= S_RELEASED;
      r_cnt        <= '0;
      r_hold_cnt   <= '0;
      r_rep_cnt    <= '0;
      r_long_fired <= 1'b0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_short      <= 1'b0;
      r_long       <= 1'b0;
      r_repeat     <= 1'b0;
    end else begin
      r_d_meta  <= d_in;
      r_d_sync  <= r_d_meta;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_acc;
      r_release <= w_rel_acc;
      r_short   <= w_rel_acc && !r_long_fired;
      r_long    <= w_long_hit;
      r_repeat  <= w_rep_hit;
      if (w_press_acc) begin
        r_hold_cnt   <= '0;
        r_rep_cnt    <= '0;
        r_long_fired <= 1'b0;
      end else if (w_held) begin
        // Saturate so a very long hold never wraps back to a long event.
        if (r_hold_cnt != {HW{1'b1}})
          r_hold_cnt <= r_hold_cnt + 1'b1;
        if (w_long_hit) begin
          r_long_fired <= 1'b1;
          r_rep_cnt    <= '0;
        end else if (r_long_fired) begin
          r_rep_cnt <= w_rep_hit ? '0 : r_rep_cnt + 1'b1;
        end
      end
    end
  end

  assign btn_level     = (r_state == S_PRESSED) ||
                         (r_state == S_RELEASE_WAIT);
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign short_pulse   = r_short;
  assign long_pulse    = r_long;
  assign repeat_pulse  = r_repeat;

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scenario tasks drive the button line and push the
// expected pulse events; a monitor collects observed events for comparison.
module tb_button_debouncer;

  localparam int S = 20;
  localparam int L = 1000;
  localparam int R = 200;

  localparam logic [4:0] K_PRESS = 5'b10000;
  localparam logic [4:0] K_REL   = 5'b01000;
  localparam logic [4:0] K_SHORT = 5'b00100;
  localparam logic [4:0] K_LONG  = 5'b00010;
  localparam logic [4:0] K_REP   = 5'b00001;

  typedef struct {
    int         e;
    logic [4:0] k;
  } ev_t;

  logic clk;
  logic reset;
  logic d_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic mon_en = 1'b0;

  ev_t exp_q[$];
  ev_t obs_q[$];

  button_debouncer #(
    .STABLE_CYCLES(S),
    .LONG_CYCLES(L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .reset(reset),
    .d_in(d_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .short_pulse(short_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wire [4:0] w_kind = {press_pulse, release_pulse, short_pulse,
                       long_pulse, repeat_pulse};

  always @(negedge clk) begin
    if (mon_en && (w_kind !== 5'b0))
      obs_q.push_back('{cyc, w_kind});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic v, input int n, output int first);
    first = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d_in = v;
      if (i == 0) first = cyc + 1;
    end
  endtask

  task automatic hold_to(input logic v, input int last);
    do begin
      @(negedge clk);
      d_in = v;
    end while (cyc + 1 < last);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d_in  = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({btn_level, w_kind} !== 6'b0)
      $display("FAIL reset_first: got %b want 000000",
               {btn_level, w_kind});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({btn_level, w_kind} !== 6'b0)
      $display("FAIL reset_held: got %b want 000000",
               {btn_level, w_kind});
    else n_pass++;
    d_in = 1'b0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_clean_press();
    int  n0, n1, t;
    ev_t e, o;
    hold(1'b1, 1, n0);
    exp_q.push_back('{n0 + S + 1, K_PRESS});
    hold(1'b1, 99, t);
    n_chk++;
    if (btn_level !== 1'b1)
      $display("FAIL clean_level_hi: got %b want 1", btn_level);
    else n_pass++;
    hold(1'b0, 1, n1);
    exp_q.push_back('{n1 + S + 1, K_REL | K_SHORT});
    hold(1'b0, 59, t);
    n_chk++;
    if (btn_level !== 1'b0)
      $display("FAIL clean_level_lo: got %b want 0", btn_level);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0)
        $display("FAIL clean_ev: got none want k=%b @%0d", e.k, e.e);
      else begin
        o = obs_q.pop_front();
        if (o.e !== e.e || o.k !== e.k)
          $display("FAIL clean_ev: got k=%b @%0d want k=%b @%0d",
                   o.k, o.e, e.k, e.e);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL clean_extra: got %0d extra events want 0",
               obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_bounce();
    logic pat [11] = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
    int   n0, n1, t;
    ev_t  e, o;
    for (int i = 0; i < 25; i++) hold(pat[i % 11], 1, t);
    hold(1'b1, 1, n0);
    exp_q.push_back('{n0 + S + 1, K_PRESS});
    hold(1'b1, 39, t);
    hold(1'b0, 1, n1);
    exp_q.push_back('{n1 + S + 1, K_REL | K_SHORT});
    hold(1'b0, 29, t);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0)
        $display("FAIL bounce_ev: got none want k=%b @%0d", e.k, e.e);
      else begin
        o = obs_q.pop_front();
        if (o.e !== e.e || o.k !== e.k)
          $display("FAIL bounce_ev: got k=%b @%0d want k=%b @%0d",
                   o.k, o.e, e.k, e.e);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL bounce_extra: got %0d extra events want 0",
               obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_near_miss();
    int t;
    hold(1'b1, S - 1, t);
    hold(1'b0, 30, t);
    n_chk++;
    if (btn_level !== 1'b0)
      $display("FAIL near_level: got %b want 0", btn_level);
    else n_pass++;
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL near_extra: got %0d events want 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_long_hold();
    int  n0, n1, p, t;
    ev_t e, o;
    hold(1'b1, 1, n0);
    p = n0 + S + 1;
    exp_q.push_back('{p, K_PRESS});
    exp_q.push_back('{p + L, K_LONG});
    hold_to(1'b1, p + 1499);
    hold(1'b0, 1, n1);
    for (int r = p + L + R; r < n1 + S + 1; r += R)
      exp_q.push_back('{r, K_REP});
    exp_q.push_back('{n1 + S + 1, K_REL});
    hold(1'b0, 29, t);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0)
        $display("FAIL long_ev: got none want k=%b @%0d", e.k, e.e);
      else begin
        o = obs_q.pop_front();
        if (o.e !== e.e || o.k !== e.k)
          $display("FAIL long_ev: got k=%b @%0d want k=%b @%0d",
                   o.k, o.e, e.k, e.e);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL long_extra: got %0d extra events want 0",
               obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_release_bounce();
    int  n0, n1, p, g, t;
    ev_t e, o;
    hold(1'b1, 1, n0);
    p = n0 + S + 1;
    exp_q.push_back('{p, K_PRESS});
    exp_q.push_back('{p + L, K_LONG});
    hold(1'b1, 29, t);
    for (int i = 0; i < 10; i++) begin
      g = 1 + (i % 3);
      hold(1'b0, g, t);
      hold(1'b1, 5 - g, t);
      n_chk++;
      if (btn_level !== 1'b1)
        $display("FAIL relb_level[%0d]: got %b want 1", i, btn_level);
      else n_pass++;
    end
    hold_to(1'b1, p + 1049);
    hold(1'b0, 1, n1);
    exp_q.push_back('{n1 + S + 1, K_REL});
    hold(1'b0, 29, t);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0)
        $display("FAIL relb_ev: got none want k=%b @%0d", e.k, e.e);
      else begin
        o = obs_q.pop_front();
        if (o.e !== e.e || o.k !== e.k)
          $display("FAIL relb_ev: got k=%b @%0d want k=%b @%0d",
                   o.k, o.e, e.k, e.e);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL relb_extra: got %0d extra events want 0",
               obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_reset_mid_press();
    int  n0, n1, p, r, t;
    ev_t e, o;
    hold(1'b1, 1, n0);
    p = n0 + S + 1;
    exp_q.push_back('{p, K_PRESS});
    hold_to(1'b1, p + 500);
    @(negedge clk);
    reset = 1'b1;
    d_in  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    r = cyc;
    n_chk++;
    if ({btn_level, w_kind} !== 6'b0)
      $display("FAIL rstmid_outs: got %b want 000000",
               {btn_level, w_kind});
    else n_pass++;
    exp_q.push_back('{r + 1 + S + 1, K_PRESS});
    hold_to(1'b1, p + 1100);
    hold(1'b0, 1, n1);
    exp_q.push_back('{n1 + S + 1, K_REL | K_SHORT});
    hold(1'b0, 29, t);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0)
        $display("FAIL rstmid_ev: got none want k=%b @%0d", e.k, e.e);
      else begin
        o = obs_q.pop_front();
        if (o.e !== e.e || o.k !== e.k)
          $display("FAIL rstmid_ev: got k=%b @%0d want k=%b @%0d",
                   o.k, o.e, e.k, e.e);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL rstmid_extra: got %0d extra events want 0",
               obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    d_in  = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_near_miss();
    test_long_hold();
    test_release_bounce();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
